// File: rtl/ups_axi4l_regs.sv
// ups_axi4l_regs: AXI4-Lite responder for the UPS control/status register map.
// Write and read channels run independent FSMs. All handshake outputs are
// flops, so the bus sees no combinational path from any input to any output.
//
// Handshake semantics: a transfer on a channel completes on the rising fclk
// edge where both its valid and ready are high. The responder raises a ready
// or valid only as the result of such an edge (or of reset release), holds it
// until the completing edge, and keeps each response payload stable while its
// valid is high.
module ups_axi4l_regs #(
    parameter int DAC_W  = 12,
    parameter int LOOP_W = 16
) (
    input  logic              fclk,
    input  logic              rst,
    input  logic [31:0]       ca4l_awaddr,
    input  logic [2:0]        ca4l_awprot,
    input  logic              ca4l_awvalid,
    output logic              ca4l_awready,
    input  logic [31:0]       ca4l_wdata,
    input  logic [3:0]        ca4l_wstrb,
    input  logic              ca4l_wvalid,
    output logic              ca4l_wready,
    output logic [1:0]        ca4l_bresp,
    output logic              ca4l_bvalid,
    input  logic              ca4l_bready,
    input  logic [31:0]       ca4l_araddr,
    input  logic [2:0]        ca4l_arprot,
    input  logic              ca4l_arvalid,
    output logic              ca4l_arready,
    output logic [31:0]       ca4l_rdata,
    output logic [1:0]        ca4l_rresp,
    output logic              ca4l_rvalid,
    input  logic              ca4l_rready,
    output logic [1:0]        mode,
    output logic [DAC_W-1:0]  dac0,
    output logic [DAC_W-1:0]  dac1,
    output logic              valve,
    output logic [LOOP_W-1:0] loops,
    output logic [31:0]       pre_cnt,
    output logic [31:0]       run_cnt,
    output logic [31:0]       post_cnt,
    output logic              start,
    output logic              stop,
    input  logic [31:0]       status
);

    // Word offsets (address bits [7:2]) of the register map.
    localparam logic [5:0] A_MODE   = 6'h00;
    localparam logic [5:0] A_DAC0   = 6'h01;
    localparam logic [5:0] A_DAC1   = 6'h02;
    localparam logic [5:0] A_VALVE  = 6'h03;
    localparam logic [5:0] A_LOOPS  = 6'h04;
    localparam logic [5:0] A_PRE    = 6'h05;
    localparam logic [5:0] A_RUN    = 6'h06;
    localparam logic [5:0] A_POST   = 6'h07;
    localparam logic [5:0] A_START  = 6'h08;
    localparam logic [5:0] A_STOP   = 6'h09;
    localparam logic [5:0] A_STATUS = 6'h10;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
    typedef enum logic       {R_IDLE, R_DATA} r_state_t;

    w_state_t    w_state, w_next;
    r_state_t    r_state, r_next;
    logic [5:0]  waddr_idx;
    logic        aw_hs, w_hs, ar_hs;
    logic        wr_mapped;
    logic [31:0] rd_data;
    logic [1:0]  rd_resp;

    // Protection, strobes and the address bits outside [7:2] carry no meaning here.
    logic unused_inputs;
    assign unused_inputs = ^{ca4l_awaddr[31:8], ca4l_awaddr[1:0], ca4l_araddr[31:8],
                             ca4l_araddr[1:0], ca4l_awprot, ca4l_arprot, ca4l_wstrb};

    assign aw_hs = ca4l_awvalid & ca4l_awready;
    assign w_hs  = ca4l_wvalid & ca4l_wready;
    assign ar_hs = ca4l_arvalid & ca4l_arready;

    // Write FSM next state: address, then data, then response.
    always_comb begin
        w_next = w_state;
        case (w_state)
            W_IDLE:  if (aw_hs) w_next = W_DATA;
            W_DATA:  if (w_hs) w_next = W_RESP;
            W_RESP:  if (ca4l_bvalid && ca4l_bready) w_next = W_IDLE;
            default: w_next = W_IDLE;
        endcase
    end

    // Write FSM state and its registered ready/valid outputs.
    always_ff @(posedge fclk or posedge rst) begin
        if (rst) begin
            w_state      <= W_IDLE;
            ca4l_awready <= 1'b0;
            ca4l_wready  <= 1'b0;
            ca4l_bvalid  <= 1'b0;
        end else begin
            w_state      <= w_next;
            ca4l_awready <= (w_next == W_IDLE);
            ca4l_wready  <= (w_next == W_DATA);
            ca4l_bvalid  <= (w_next == W_RESP);
        end
    end

    // STATUS accepts (and ignores) writes; everything past STOP is unmapped.
    always_comb begin
        wr_mapped = (waddr_idx <= A_STOP) || (waddr_idx == A_STATUS);
    end

    // Address capture, register updates, write response and one-cycle strobes.
    always_ff @(posedge fclk or posedge rst) begin
        if (rst) begin
            waddr_idx  <= '0;
            ca4l_bresp <= RESP_OKAY;
            mode       <= '0;
            dac0       <= '0;
            dac1       <= '0;
            valve      <= 1'b0;
            loops      <= '0;
            pre_cnt    <= '0;
            run_cnt    <= '0;
            post_cnt   <= '0;
            start      <= 1'b0;
            stop       <= 1'b0;
        end else begin
            start <= 1'b0;
            stop  <= 1'b0;
            if (aw_hs) begin
                waddr_idx <= ca4l_awaddr[7:2];
            end
            if (w_hs) begin
                ca4l_bresp <= wr_mapped ? RESP_OKAY : RESP_SLVERR;
                case (waddr_idx)
                    A_MODE:  mode     <= ca4l_wdata[1:0];
                    A_DAC0:  dac0     <= ca4l_wdata[DAC_W-1:0];
                    A_DAC1:  dac1     <= ca4l_wdata[DAC_W-1:0];
                    A_VALVE: valve    <= ca4l_wdata[0];
                    A_LOOPS: loops    <= ca4l_wdata[LOOP_W-1:0];
                    A_PRE:   pre_cnt  <= ca4l_wdata;
                    A_RUN:   run_cnt  <= ca4l_wdata;
                    A_POST:  post_cnt <= ca4l_wdata;
                    A_START: start    <= 1'b1;
                    A_STOP:  stop     <= 1'b1;
                    default: ;
                endcase
            end
        end
    end

    // Read mux on the presented read address; narrow fields zero-extend.
    always_comb begin
        rd_data = '0;
        rd_resp = RESP_OKAY;
        case (ca4l_araddr[7:2])
            A_MODE:   rd_data = 32'(mode);
            A_DAC0:   rd_data = 32'(dac0);
            A_DAC1:   rd_data = 32'(dac1);
            A_VALVE:  rd_data = 32'(valve);
            A_LOOPS:  rd_data = 32'(loops);
            A_PRE:    rd_data = pre_cnt;
            A_RUN:    rd_data = run_cnt;
            A_POST:   rd_data = post_cnt;
            A_START:  rd_data = '0;
            A_STOP:   rd_data = '0;
            A_STATUS: rd_data = status;
            default:  rd_resp = RESP_SLVERR;
        endcase
    end

    // Read FSM next state: address, then data.
    always_comb begin
        r_next = r_state;
        case (r_state)
            R_IDLE:  if (ar_hs) r_next = R_DATA;
            R_DATA:  if (ca4l_rvalid && ca4l_rready) r_next = R_IDLE;
            default: r_next = R_IDLE;
        endcase
    end

    // Read FSM state, handshake outputs and the data captured at the AR edge.
    always_ff @(posedge fclk or posedge rst) begin
        if (rst) begin
            r_state      <= R_IDLE;
            ca4l_arready <= 1'b0;
            ca4l_rvalid  <= 1'b0;
            ca4l_rdata   <= '0;
            ca4l_rresp   <= RESP_OKAY;
        end else begin
            r_state      <= r_next;
            ca4l_arready <= (r_next == R_IDLE);
            ca4l_rvalid  <= (r_next == R_DATA);
            if (ar_hs) begin
                ca4l_rdata <= rd_data;
                ca4l_rresp <= rd_resp;
            end
        end
    end

endmodule

// File: doc/ups_axi4l_regs.md
# ups_axi4l_regs

AXI4-Lite responder (slave) holding the UPS control/status register map that the PS-side initiator drives over the `ca4l_*` bus. It completes write and read transactions, exposes the stored control fields (mode, DAC codes, valve, sequence counts) as registered outputs, and generates single-cycle start/stop strobes for the run sequencer. It sits between the Zynq GP master port and the UPS datapath, in the `fclk` domain.

## Interface
- `DAC_W`, 12: width of DAC0/DAC1 code fields.
- `LOOP_W`, 16: width of loop-count field.
- `fclk  in  1`: sole clock; all logic on the rising edge.
- `rst  in  1`: asynchronous, active-high reset.
- `ca4l_awaddr  in  32`, `ca4l_awprot  in  3`, `ca4l_awvalid  in  1`, `ca4l_awready  out  1`: write address channel.
- `ca4l_wdata  in  32`, `ca4l_wstrb  in  4`, `ca4l_wvalid  in  1`, `ca4l_wready  out  1`: write data channel.
- `ca4l_bresp  out  2`, `ca4l_bvalid  out  1`, `ca4l_bready  in  1`: write response channel.
- `ca4l_araddr  in  32`, `ca4l_arprot  in  3`, `ca4l_arvalid  in  1`, `ca4l_arready  out  1`: read address channel.
- `ca4l_rdata  out  32`, `ca4l_rresp  out  2`, `ca4l_rvalid  out  1`, `ca4l_rready  in  1`: read data channel.
- `mode  out  2`: operating mode (2 = DEBUG, 3 = RUN).
- `dac0`, `dac1  out  DAC_W`: DAC codes.
- `valve  out  1`: valve drive.
- `loops  out  LOOP_W`, `pre_cnt`, `run_cnt`, `post_cnt  out  32`: sequence counts.
- `start`, `stop  out  1`: one-cycle strobes.
- `status  in  32`: sequencer status, sampled on read.

## Operation
- Decode on `addr[7:2]`. `addr[31:8]` and `addr[1:0]` ignored. `awprot`/`arprot` ignored. `wstrb` ignored: every accepted write is a full 32-bit write, including when `wstrb = 0`.
- Map (RW unless noted; narrow fields zero-extended on read, excess write bits dropped):
  - 0x00 MODE[1:0]
  - 0x04 DAC0[DAC_W-1:0]
  - 0x08 DAC1[DAC_W-1:0]
  - 0x0C VALVE[0]
  - 0x10 LOOPS[LOOP_W-1:0]
  - 0x14 PRE_CNT[31:0]
  - 0x18 RUN_CNT[31:0]
  - 0x1C POST_CNT[31:0]
  - 0x20 START, write-only strobe; data ignored; reads 0.
  - 0x24 STOP, write-only strobe; data ignored; reads 0.
  - 0x40 STATUS, read-only; writes are ignored and respond OKAY.
- Any other offset: the write is discarded with `bresp = 2'b10` (SLVERR). A read returns `rdata = 0` with `rresp = 2'b10`. All mapped accesses return OKAY (`2'b00`).
- Write FSM states:
  - W_IDLE (`awready = 1`): on `awvalid & awready`, capture `awaddr` and go to W_DATA.
  - W_DATA (`wready = 1`): on `wvalid & wready`, update the register, set `bresp`, go to W_RESP.
  - W_RESP (`bvalid = 1`): on `bready`, return to W_IDLE.
- Read FSM states:
  - R_IDLE (`arready = 1`): on `arvalid & arready`, register `rdata`/`rresp` (sampling `status` at that edge) and go to R_DATA.
  - R_DATA (`rvalid = 1`): on `rready`, return to R_IDLE.
- Read and write FSMs are independent and may run concurrently.

## Timing
- Reset values:
  - All ready/valid outputs 0; `bresp`, `rresp`, `rdata` 0.
  - All control outputs 0; `start`/`stop` 0.
  - Both FSMs start in IDLE.
- `awready`/`arready` are flops: they rise on the first `fclk` edge after `rst` deasserts.
- All handshake outputs are registered and change only on the edge where the handshake completes.
- Write timing:
  - W is never accepted in the same cycle as AW; if `wvalid` is already high, `wready` rises the cycle after the AW handshake.
  - Control outputs update on the W handshake edge.
  - `bvalid` is high the cycle after the W handshake and holds until `bready`; `awready` stays 0 meanwhile.
- Strobes: `start`/`stop` go high for exactly one cycle, the cycle after the W handshake. Back-to-back writes to START give separate pulses.
- Read timing:
  - `rvalid` is high the cycle after the AR handshake.
  - `rdata` is held stable until the `rready` handshake; `arready` stays 0 meanwhile.
  - Minimum read turnaround is 2 cycles; minimum write turnaround is 3 cycles.
- Read and write hitting the same register on the same edge: the read returns the pre-write value.
- `rst` mid-transaction: the transaction is dropped, registers return to 0, and no strobe is emitted.

## Test plan
- Write 0x00 = 0x2, then read 0x00: `bresp = 00`, `mode = 2`, `rdata = 0x00000002`, `rresp = 00`.
- Write 0x04 = 0x800 with `wstrb = 0`, then write 0x08 = 0xFFFFFC00: `dac0 = 0x800`, `dac1 = 0xC00`. Readback returns 0x00000800 and 0x00000C00.
- Write 0x14/0x18/0x1C = 2/1/3, then write 0x20: `start` high exactly 1 cycle, one cycle after the W handshake; `stop` stays 0; read 0x20 returns 0.
- Drive `status = 0xA5A50001`, read 0x40: `rdata = 0xA5A50001`, OKAY. Then write 0x30 = 0xFFFFFFFF: `bresp = 10`, all outputs unchanged; read 0x30 gives 0 with `rresp = 10`.
- Backpressure: hold `bready` low 10 cycles after a write, and `rready` low 10 cycles after a read. Required: `bvalid`/`rvalid`/`rdata` held stable; `awready`/`arready` stay 0; FSMs release one cycle after the ready handshake.
- Assert `rst` while in W_DATA with `valve = 1` and a write to 0x24 pending. Required: all outputs 0 immediately, no `stop` pulse, `awready = 1` one edge after release.
